// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink driver: state encodings, default
// timing derived from the system clock, and the phase-timer width helper.
package led_blink_pkg;

    localparam logic [1:0] LED_BLINK_IDLE = 2'd0;
    localparam logic [1:0] LED_BLINK_ON   = 2'd1;
    localparam logic [1:0] LED_BLINK_OFF  = 2'd2;

    localparam int SYS_CLK_HZ         = 24_000_000;
    localparam int DEFAULT_ON_CYCLES  = SYS_CLK_HZ / 2;
    localparam int DEFAULT_OFF_CYCLES = SYS_CLK_HZ / 2;

    // Width able to hold 0..max(on,off)-1; never narrower than one bit.
    function automatic int timer_width(input int on_c, input int off_c);
        int m;
        m = (on_c > off_c) ? on_c : off_c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_blink_phase_timer.sv
// Loadable/clearable up-counter with a terminal-count flag. Holds at the
// terminal value instead of wrapping; clear has priority over load.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = (cnt_q == tc_val);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && !tc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_blink.sv
// Plays N timed on/off blinks on an LED per single-cycle trigger.
// Optional one-entry request queue enabled by defining LED_BLINK_QUEUE_EN.
module led_blink
    import led_blink_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             led,
    output logic             done
);

    localparam int             TW     = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0]  ON_TC  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]  OFF_TC = TW'(OFF_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmr_clr;
    logic             tmr_tc;
    logic [TW-1:0]    tmr_tc_val;

`ifdef LED_BLINK_QUEUE_EN
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
`endif

    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] c);
        return (c == '0) ? CNT_W'(1) : c;
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
`ifdef LED_BLINK_QUEUE_EN
        pend_vld_d  = pend_vld_q;
        pend_cnt_d  = pend_cnt_q;
`endif
        case (state_q)
            LED_BLINK_IDLE: begin
`ifdef LED_BLINK_QUEUE_EN
                // Draining the buffer frees it, so a coincident trigger refills it.
                if (pend_vld_q) begin
                    state_d     = LED_BLINK_ON;
                    remaining_d = eff_count(pend_cnt_q);
                    pend_vld_d  = trigger;
                    pend_cnt_d  = trigger ? count : pend_cnt_q;
                end else
`endif
                if (trigger) begin
                    state_d     = LED_BLINK_ON;
                    remaining_d = eff_count(count);
                end
            end
            LED_BLINK_ON: begin
                if (tmr_tc) begin
                    state_d = LED_BLINK_OFF;
                end
            end
            LED_BLINK_OFF: begin
                if (tmr_tc) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = LED_BLINK_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LED_BLINK_ON;
                    end
                end
            end
            default: begin
                state_d = LED_BLINK_IDLE;
            end
        endcase
`ifdef LED_BLINK_QUEUE_EN
        if (state_q != LED_BLINK_IDLE && trigger && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_cnt_d = count;
        end
`endif
    end

    // Outputs are decoded from the next state so they change on the same edge.
    assign led_d      = (state_d == LED_BLINK_ON);
    assign busy_d     = (state_d != LED_BLINK_IDLE);
    assign tmr_tc_val = (state_q == LED_BLINK_ON) ? ON_TC : OFF_TC;
    assign tmr_clr    = (state_d != state_q) || (state_q == LED_BLINK_IDLE);

    phase_timer #(
        .W(TW)
    ) u_phase_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .load    (1'b0),
        .load_val({TW{1'b0}}),
        .en      (1'b1),
        .tc_val  (tmr_tc_val),
        .tc      (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LED_BLINK_IDLE;
            remaining_q <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef LED_BLINK_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_cnt_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end
`endif

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_blink.sv
// Directed bench for led_blink with ON_CYCLES=4, OFF_CYCLES=3, CNT_W=4.
// Index i below is the observation taken 1 ns after the i-th edge past the trigger edge.
module tb_led_blink;

    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trigger;
    logic [CW-1:0] count;
    logic          busy;
    logic          led;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_blink #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .CNT_W     (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .trigger(trigger),
        .count  (count),
        .busy   (busy),
        .led    (led),
        .done   (done)
    );

    // Drive one trigger; returns 1 ns after the edge that sampled it (index 0).
    task automatic fire(input logic [CW-1:0] c);
        trigger = 1'b1;
        count   = c;
        @(posedge clk);
        #1;
        trigger = 1'b0;
    endtask

    task automatic idle_gap();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        trigger = 1'b0;
        count   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({led, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held {led,busy,done} got %b expected 000", {led, busy, done});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({led, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle cyc %0d {led,busy,done} got %b expected 000", i, {led, busy, done});
            end
        end
    endtask

    task automatic test_two_blinks();
        logic [2:0] exp;
        fire(4'd2);
        for (int i = 0; i < 16; i++) begin
            exp = {(i < 4) || (i >= 7 && i < 11), i < 14, i == 14};
            checks++;
            if ({led, busy, done} !== exp) begin
                errors++;
                $display("FAIL two_blinks idx %0d {led,busy,done} got %b expected %b", i, {led, busy, done}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_count_zero();
        logic [2:0] exp;
        fire(4'd0);
        for (int i = 0; i < 10; i++) begin
            exp = {i < 4, i < 7, i == 7};
            checks++;
            if ({led, busy, done} !== exp) begin
                errors++;
                $display("FAIL count_zero idx %0d {led,busy,done} got %b expected %b", i, {led, busy, done}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp;
        fire(4'd3);
        for (int i = 0; i < 9; i++) begin
            exp = {(i < 4) || (i >= 7), 1'b1, 1'b0};
            checks++;
            if ({led, busy, done} !== exp) begin
                errors++;
                $display("FAIL reset_mid_pre idx %0d {led,busy,done} got %b expected %b", i, {led, busy, done}, exp);
            end
            if (i < 8) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_async {led,busy,done} got %b expected 000", {led, busy, done});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({led, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_hold cyc %0d {led,busy,done} got %b expected 000", i, {led, busy, done});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({led, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_release cyc %0d {led,busy,done} got %b expected 000", i, {led, busy, done});
            end
        end
        fire(4'd1);
        for (int i = 0; i < 10; i++) begin
            exp = {i < 4, i < 7, i == 7};
            checks++;
            if ({led, busy, done} !== exp) begin
                errors++;
                $display("FAIL reset_mid_restart idx %0d {led,busy,done} got %b expected %b", i, {led, busy, done}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Second trigger two edges after the first; optionally a third while one is pending.
    task automatic test_back_to_back(input bit third);
        logic [2:0] exp;
        int         dones;
        dones = 0;
        fire(4'd1);
        for (int i = 0; i < 28; i++) begin
            if (i == 1) begin
                trigger = 1'b1;
                count   = 4'd2;
            end else if (third && i == 3) begin
                trigger = 1'b1;
                count   = 4'd3;
            end else begin
                trigger = 1'b0;
            end
`ifdef LED_BLINK_QUEUE_EN
            exp = {(i < 4) || (i >= 8 && i < 12) || (i >= 15 && i < 19),
                   (i < 7) || (i >= 8 && i < 22),
                   (i == 7) || (i == 22)};
`else
            exp = {i < 4, i < 7, i == 7};
`endif
            checks++;
            if ({led, busy, done} !== exp) begin
                errors++;
                $display("FAIL back_to_back third=%0d idx %0d {led,busy,done} got %b expected %b",
                         third, i, {led, busy, done}, exp);
            end
            if (done === 1'b1) dones++;
            @(posedge clk);
            #1;
        end
        trigger = 1'b0;
        checks++;
`ifdef LED_BLINK_QUEUE_EN
        if (dones != 2) begin
            errors++;
            $display("FAIL back_to_back_dones third=%0d got %0d expected 2", third, dones);
        end
`else
        if (dones != 1) begin
            errors++;
            $display("FAIL back_to_back_dones third=%0d got %0d expected 1", third, dones);
        end
`endif
    endtask

    initial begin
        test_reset();
        idle_gap();
        test_two_blinks();
        idle_gap();
        test_count_zero();
        idle_gap();
        test_reset_mid();
        idle_gap();
        test_back_to_back(1'b0);
        idle_gap();
        test_back_to_back(1'b1);
        idle_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
